// File: rtl/mem_pkg.sv
// Shared definitions for memory-side blocks: sweep FSM encoding, access modes
// and the default bus widths.
package mem_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/sweep_addr_gen.sv
// Sweep address register: loads the first cell, steps modulo 2^ADDR_W and
// flags the last cell of the latched inclusive window.
module sweep_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] end_q;

  // Natural wrap of the adder gives the all-ones -> 0 step of a full sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      end_q <= '0;
    end else if (load) begin
      addr  <= start_addr;
      end_q <= end_addr;
    end else if (inc) begin
      addr  <= addr + 1'b1;
    end
  end

  assign last = (addr == end_q);

endmodule

// File: rtl/mem_sweeper.sv
// Programmable-window memory sweeper: read-scan with checksum or write-fill,
// one 4-phase request/response handshake per cell, with abort and timeout.
module mem_sweeper
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int CHK_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  input  logic              memory_response,
  input  logic [DATA_W-1:0] memory_data_in,
  output logic [ADDR_W-1:0] locator_bus,
  output logic              memory_request,
  output logic              memory_mode,
  output logic [DATA_W-1:0] memory_data_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CHK_W-1:0]  checksum,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]        state;
  logic              launch;
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic              abort_q;
  logic [TW-1:0]     timer;
  logic              idle_like;
  logic              load;
  logic              inc;
  logic              last;
  logic              finish;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign load      = idle_like && start && !launch;
  assign finish    = last || abort_q || abort;
  assign inc       = (state == ST_ACK) && !memory_response && !finish;

  sweep_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .inc        (inc),
    .addr       (locator_bus),
    .last       (last)
  );

  // launch spends one cycle between sampling start and raising the request,
  // so done/error stay visible until REQ is actually entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      launch     <= 1'b0;
      mode_q     <= MODE_READ;
      fill_q     <= '0;
      abort_q    <= 1'b0;
      timer      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      checksum   <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (launch) begin
            state   <= ST_REQ;
            launch  <= 1'b0;
            timer   <= '0;
            abort_q <= 1'b0;
          end else if (start) begin
            launch   <= 1'b1;
            mode_q   <= mode;
            fill_q   <= fill_data;
            checksum <= '0;
          end
        end
        ST_REQ: begin
          abort_q <= abort_q | abort;
          if (memory_response) begin
            state <= ST_ACK;
            if (mode_q == MODE_READ) begin
              data_out   <= memory_data_in;
              data_valid <= 1'b1;
              checksum   <= checksum + CHK_W'(memory_data_in);
            end
          end else if ((TIMEOUT > 0) && (timer == TW'(TIMEOUT - 1))) begin
            state <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_ACK: begin
          abort_q <= abort_q | abort;
          if (!memory_response) begin
            if (finish) begin
              state <= ST_DONE;
            end else begin
              state <= ST_REQ;
              timer <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign memory_request  = (state == ST_REQ);
  assign memory_mode     = mode_q;
  assign memory_data_out = fill_q;
  assign busy            = (state == ST_REQ) || (state == ST_ACK);
  assign done            = (state == ST_DONE);
  assign error           = (state == ST_ERROR);

endmodule

// File: tb/tb_mem_sweeper.sv
// Directed bench for mem_sweeper: small memory model answering after two
// cycles with data = addr[7:0], plus a negedge monitor of handshakes.
module tb_mem_sweeper;
  import mem_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int CHK_W   = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              abort = 1'b0;
  logic              memory_response = 1'b0;
  logic [DATA_W-1:0] memory_data_in = '0;
  logic [ADDR_W-1:0] locator_bus;
  logic              memory_request;
  logic              memory_mode;
  logic [DATA_W-1:0] memory_data_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [CHK_W-1:0]  checksum;
  logic              busy;
  logic              done;
  logic              error;

  mem_sweeper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .start_addr(start_addr),
    .end_addr(end_addr), .fill_data(fill_data), .abort(abort),
    .memory_response(memory_response), .memory_data_in(memory_data_in),
    .locator_bus(locator_bus), .memory_request(memory_request), .memory_mode(memory_mode),
    .memory_data_out(memory_data_out), .data_out(data_out), .data_valid(data_valid),
    .checksum(checksum), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory model: response two negedges into a request, dropped once request falls.
  bit mem_en = 1'b1;
  int lat_cnt = 0;
  always @(negedge clk) begin
    if (memory_request && mem_en) begin
      lat_cnt++;
      if (lat_cnt >= 2) begin
        memory_response = 1'b1;
        memory_data_in  = locator_bus[7:0];
      end
    end else if (!memory_request) begin
      memory_response = 1'b0;
      lat_cnt = 0;
    end
  end

  int                req_rises, req_cyc, vcount;
  logic [ADDR_W-1:0] aq[$];
  logic              mq[$];
  logic [DATA_W-1:0] dq[$];
  logic [DATA_W-1:0] vq[$];
  logic              prev_req = 1'b0;

  always @(negedge clk) begin
    if (memory_request) req_cyc++;
    if (memory_request && !prev_req) begin
      req_rises++;
      aq.push_back(locator_bus);
      mq.push_back(memory_mode);
      dq.push_back(memory_data_out);
    end
    if (data_valid) begin
      vcount++;
      vq.push_back(data_out);
    end
    prev_req = memory_request;
  end

  task automatic clear_mon();
    req_rises = 0; req_cyc = 0; vcount = 0;
    aq.delete(); mq.delete(); dq.delete(); vq.delete();
  endtask

  task automatic do_start(input logic m, input logic [ADDR_W-1:0] sa,
                          input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] fd);
    @(negedge clk);
    mode = m; start_addr = sa; end_addr = ea; fill_data = fd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_edge_n", memory_request, 1'b0);
    @(negedge clk);
    chk("lat_edge_n1", memory_request, 1'b1);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("end_reached", done | error, 1'b1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_req", memory_request, 1'b0);
    chk("rst_stat", {busy, done, error, data_valid}, 4'b0);
    chk("rst_loc", locator_bus, 16'h0);
    chk("rst_chk", checksum, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // read window 0x10..0x13
    clear_mon();
    do_start(MODE_READ, 16'h0010, 16'h0013, 8'h00);
    wait_end(200);
    chk("rd_done", done, 1'b1);
    chk("rd_err", error, 1'b0);
    chk("rd_vcount", vcount, 4);
    chk("rd_rises", req_rises, 4);
    for (int i = 0; i < 4; i++)
      chk("rd_data", (i < vq.size()) ? 32'(vq[i]) : 32'hDEAD, 32'h10 + i);
    chk("rd_checksum", checksum, 16'h0046);

    // write-fill across the wrap point
    clear_mon();
    do_start(MODE_WRITE, 16'hFFFE, 16'h0001, 8'hA5);
    wait_end(200);
    chk("wr_done", done, 1'b1);
    chk("wr_rises", req_rises, 4);
    chk("wr_vcount", vcount, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", (i < aq.size()) ? 32'(aq[i]) : 32'hDEAD, 32'((16'hFFFE + i) & 16'hFFFF));
      chk("wr_mode", (i < mq.size()) ? 32'(mq[i]) : 32'hDEAD, 32'd1);
      chk("wr_wdata", (i < dq.size()) ? 32'(dq[i]) : 32'hDEAD, 32'hA5);
    end

    // single-cell window
    clear_mon();
    do_start(MODE_READ, 16'h1234, 16'h1234, 8'h00);
    begin
      int n = 0;
      while (!memory_response && n < 50) begin @(posedge clk); #1; n++; end
      chk("one_resp_seen", memory_response, 1'b1);
      n = 0;
      while (memory_response && n < 50) begin @(posedge clk); #1; n++; end
      chk("one_resp_rel", memory_response, 1'b0);
      n = 0;
      while (!done && n < 2) begin @(posedge clk); #1; n++; end
      chk("one_done_after_rel", done, 1'b1);
    end
    @(negedge clk);
    chk("one_rises", req_rises, 1);
    chk("one_vcount", vcount, 1);
    chk("one_data", data_out, 8'h34);
    chk("one_checksum", checksum, 16'h0034);

    // timeout with a silent memory
    mem_en = 1'b0;
    clear_mon();
    do_start(MODE_READ, 16'h0500, 16'h0510, 8'h00);
    wait_end(200);
    chk("to_error", error, 1'b1);
    chk("to_done", done, 1'b0);
    chk("to_req_cycles", req_cyc, 8);
    chk("to_loc", locator_bus, 16'h0500);
    chk("to_req_low", memory_request, 1'b0);
    mem_en = 1'b1;
    clear_mon();
    @(negedge clk);
    mode = MODE_READ; start_addr = 16'h0600; end_addr = 16'h0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_err_hold", error, 1'b1);
    @(negedge clk);
    chk("to_err_clear", error, 1'b0);
    chk("to_busy", busy, 1'b1);
    wait_end(200);
    chk("to_restart_done", done, 1'b1);
    chk("to_restart_vcount", vcount, 1);

    // abort during the third cell of 0..9
    clear_mon();
    do_start(MODE_READ, 16'h0000, 16'h0009, 8'h00);
    begin
      int n = 0;
      while (!(memory_request && locator_bus == 16'h0002) && n < 200) begin @(negedge clk); n++; end
      chk("ab_third_cell", locator_bus, 16'h0002);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_end(200);
    chk("ab_done", done, 1'b1);
    chk("ab_vcount", vcount, 3);
    chk("ab_rises", req_rises, 3);
    chk("ab_checksum", checksum, 16'h0003);

    // asynchronous reset mid-REQ, then a clean restart
    clear_mon();
    do_start(MODE_WRITE, 16'h0020, 16'h0030, 8'h5A);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", memory_request, 1'b0);
    chk("ar_stat", {busy, done, error, data_valid, memory_mode}, 5'b0);
    chk("ar_loc", locator_bus, 16'h0);
    chk("ar_dout", {data_out, memory_data_out}, 16'h0);
    chk("ar_chk", checksum, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    do_start(MODE_READ, 16'h0040, 16'h0041, 8'h00);
    chk("ar_restart_loc", locator_bus, 16'h0040);
    wait_end(200);
    chk("ar_restart_done", done, 1'b1);
    chk("ar_restart_vcount", vcount, 2);
    chk("ar_restart_checksum", checksum, 16'h0081);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
